// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-byte holding register on a valid/ready stream.
// Flags stop-bit framing errors and overruns as single-cycle pulses.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 dev_clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  // state | meaning
  // IDLE  | line idle, waiting for a falling edge on rx_s
  // START | timing to the middle of the start bit, rejecting glitches
  // DATA  | sampling DATA_BITS bits at mid-bit, LSB first
  // STOP  | sampling the stop bit, then handing the byte off
  // BREAK | line held low after a framing error, waiting for idle
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_t                state, state_nxt;
  logic [CW-1:0]         clk_cnt, clk_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  rx_m, rx_s;
  logic                  shift_en, stop_good, stop_bad, hold_free;

  always_comb begin
    state_nxt = state;
    clk_nxt   = clk_cnt;
    bit_nxt   = bit_cnt;
    shift_en  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          clk_nxt   = '0;
        end
      end
      START: begin
        if (clk_cnt == HALF_TC) begin
          clk_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          clk_nxt = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt == BIT_TC) begin
          clk_nxt  = '0;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + BW'(1);
          end
        end else begin
          clk_nxt = clk_cnt + CW'(1);
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
        if (clk_cnt == BIT_TC) begin
          clk_nxt = '0;
          bit_nxt = '0;
          if (rx_s) begin
            stop_good = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          clk_nxt = clk_cnt + CW'(1);
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A transfer in the same cycle as a new byte frees the holding register.
  assign hold_free = !m_valid || m_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge dev_clk) begin
    if (!rst_n) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      state   <= state_nxt;
      clk_cnt <= clk_nxt;
      bit_cnt <= bit_nxt;
      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      if (stop_good && hold_free) begin
        m_data  <= shift_reg;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      overrun   <= stop_good && !hold_free;
      frame_err <= stop_bad;
    end
  end

endmodule
